// File: rtl/nsu_pkg.sv
// Shared definitions for the NoC slave write engine: header/response field layout and FSM encoding.
package nsu_pkg;

    localparam int LEN_W        = 8;
    localparam int BRESP_W      = 2;
    localparam int HDR_ADDR_LSB = 0;
    localparam int RSP_SRC_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_AW,
        ST_W,
        ST_B,
        ST_RSP
    } state_t;

    // Head flit: addr | len | src_id, packed upward from bit 0
    function automatic int hdr_len_lsb(input int addr_w);
        return HDR_ADDR_LSB + addr_w;
    endfunction

    function automatic int hdr_src_lsb(input int addr_w);
        return HDR_ADDR_LSB + addr_w + LEN_W;
    endfunction

    // Response flit: SOURCE_ID | destination | bresp, packed upward from bit 0
    function automatic int rsp_dst_lsb(input int id_w);
        return RSP_SRC_LSB + id_w;
    endfunction

    function automatic int rsp_bresp_lsb(input int id_w);
        return RSP_SRC_LSB + 2 * id_w;
    endfunction

endpackage

// File: rtl/nsu_vc_fifo.sv
// Synchronous first-word-fall-through FIFO backing one virtual channel.
module nsu_vc_fifo
    import nsu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nsu_vc_write_engine.sv
// NoC-to-AXI write engine: buffers flits per VC, drains complete packets as AXI write bursts.
// Define NSU_WR_RESP_EN to return a single-flit write response to the requester.
module nsu_vc_write_engine
    import nsu_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 128,
    parameter int                  VC_NUM         = 4,
    parameter int                  FIFO_DEPTH     = 16,
    parameter int                  ID_WIDTH       = 4,
    parameter int                  AXI_ADDR_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] SOURCE_ID      = {ID_WIDTH{1'b1}}
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst,
    input  logic [DATA_WIDTH-1:0]      s_flit_data,
    input  logic [$clog2(VC_NUM)-1:0]  s_flit_vc,
    input  logic                       s_valid,
    input  logic                       s_is_tail,
    output logic [VC_NUM-1:0]          s_vc_ready,
    output logic [ID_WIDTH-1:0]        m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]  m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [DATA_WIDTH-1:0]      m_axi_wdata,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [DATA_WIDTH-1:0]      m_flit_data,
    output logic                       m_valid,
    input  logic                       noc_ready
);

    localparam int VC_W    = $clog2(VC_NUM);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_LSB = hdr_len_lsb(AXI_ADDR_WIDTH);
    localparam int SRC_LSB = hdr_src_lsb(AXI_ADDR_WIDTH);

    logic [VC_NUM-1:0]                 fifo_push;
    logic [VC_NUM-1:0]                 fifo_pop;
    logic [VC_NUM-1:0]                 fifo_full;
    logic [VC_NUM-1:0]                 fifo_empty;
    logic [VC_NUM-1:0][DATA_WIDTH-1:0] fifo_head;
    logic [VC_NUM-1:0]                 cnt_inc;
    logic [VC_NUM-1:0]                 cnt_dec;
    logic [VC_NUM-1:0][CNT_W-1:0]      pkt_cnt;

    state_t                    state;
    state_t                    state_nxt;
    logic [VC_W-1:0]           rr_ptr;
    logic [VC_W-1:0]           sel_vc;
    logic [VC_W-1:0]           win_vc;
    logic [VC_W-1:0]           arb_idx;
    logic                      win_found;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]          len_q;
    logic [ID_WIDTH-1:0]       src_q;
    logic [LEN_W-1:0]          beat_cnt;
    logic                      w_fire;
    logic                      last_beat;

    assign s_vc_ready = ~fifo_full;
    assign w_fire     = m_axi_wvalid && m_axi_wready;
    assign last_beat  = (beat_cnt == len_q);

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign fifo_push[v] = s_valid && (s_flit_vc == VC_W'(v)) && !fifo_full[v];
        assign fifo_pop[v]  = (sel_vc == VC_W'(v)) && ((state == ST_HDR) || w_fire);
        assign cnt_inc[v]   = fifo_push[v] && s_is_tail;
        assign cnt_dec[v]   = (sel_vc == VC_W'(v)) && (state == ST_HDR);

        nsu_vc_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (noc_clk),
            .rst       (noc_rst),
            .push      (fifo_push[v]),
            .push_data (s_flit_data),
            .pop       (fifo_pop[v]),
            .head      (fifo_head[v]),
            .full      (fifo_full[v]),
            .empty     (fifo_empty[v])
        );
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            pkt_cnt <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (cnt_inc[v] && !cnt_dec[v]) begin
                    pkt_cnt[v] <= pkt_cnt[v] + 1'b1;
                end else if (cnt_dec[v] && !cnt_inc[v]) begin
                    pkt_cnt[v] <= pkt_cnt[v] - 1'b1;
                end
            end
        end
    end

    // Scan from the highest offset down so the VC nearest rr_ptr wins
    always_comb begin
        win_found = 1'b0;
        win_vc    = rr_ptr;
        arb_idx   = rr_ptr;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            arb_idx = rr_ptr + VC_W'(i);
            if (pkt_cnt[arb_idx] != '0) begin
                win_found = 1'b1;
                win_vc    = arb_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (win_found) state_nxt = ST_HDR;
            ST_HDR:  state_nxt = ST_AW;
            ST_AW:   if (m_axi_awready) state_nxt = ST_W;
            ST_W:    if (w_fire && last_beat) state_nxt = ST_B;
`ifdef NSU_WR_RESP_EN
            ST_B:    if (m_axi_bvalid) state_nxt = ST_RSP;
            ST_RSP:  if (noc_ready) state_nxt = ST_IDLE;
`else
            ST_B:    if (m_axi_bvalid) state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            sel_vc   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            src_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && win_found) begin
                sel_vc <= win_vc;
                rr_ptr <= win_vc + VC_W'(1);
            end
            if (state == ST_HDR) begin
                addr_q   <= fifo_head[sel_vc][HDR_ADDR_LSB +: AXI_ADDR_WIDTH];
                len_q    <= fifo_head[sel_vc][LEN_LSB +: LEN_W];
                src_q    <= fifo_head[sel_vc][SRC_LSB +: ID_WIDTH];
                beat_cnt <= '0;
            end else if (w_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Handshakes are masked while reset is high so an in-flight burst issues nothing more
    assign m_axi_awid    = src_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awvalid = (state == ST_AW) && !noc_rst;
    assign m_axi_wdata   = fifo_head[sel_vc];
    assign m_axi_wvalid  = (state == ST_W) && !fifo_empty[sel_vc] && !noc_rst;
    assign m_axi_wlast   = (state == ST_W) && last_beat && !noc_rst;
    assign m_axi_bready  = (state == ST_B) && !noc_rst;

`ifdef NSU_WR_RESP_EN
    localparam int DST_LSB   = rsp_dst_lsb(ID_WIDTH);
    localparam int BRESP_LSB = rsp_bresp_lsb(ID_WIDTH);

    logic [BRESP_W-1:0]    bresp_q;
    logic [DATA_WIDTH-1:0] rsp_flit;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            bresp_q <= '0;
        end else if (state == ST_B && m_axi_bvalid) begin
            bresp_q <= m_axi_bresp;
        end
    end

    always_comb begin
        rsp_flit = '0;
        rsp_flit[RSP_SRC_LSB +: ID_WIDTH] = SOURCE_ID;
        rsp_flit[DST_LSB +: ID_WIDTH]     = src_q;
        rsp_flit[BRESP_LSB +: BRESP_W]    = bresp_q;
    end

    assign m_valid     = (state == ST_RSP) && !noc_rst;
    assign m_flit_data = rsp_flit;
`else
    assign m_valid     = 1'b0;
    assign m_flit_data = '0;
`endif

endmodule

// File: tb/tb_nsu_vc_write_engine.sv
// Scoreboard bench for nsu_vc_write_engine: expected AW/W/response traffic queued at stimulus time.
module tb_nsu_vc_write_engine;
    import nsu_pkg::*;

    logic         noc_clk = 1'b0;
    logic         noc_rst;
    logic [127:0] s_flit_data;
    logic [1:0]   s_flit_vc;
    logic         s_valid;
    logic         s_is_tail;
    logic [3:0]   s_vc_ready;
    logic [3:0]   m_axi_awid;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [127:0] m_axi_wdata;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;
    logic [127:0] m_flit_data;
    logic         m_valid;
    logic         noc_ready;

    logic aw_hold = 1'b0;
    logic w_hold  = 1'b0;
    assign m_axi_awready = !aw_hold;
    assign m_axi_wready  = !w_hold;

    always #5 noc_clk = ~noc_clk;

    nsu_vc_write_engine dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .s_flit_data   (s_flit_data),
        .s_flit_vc     (s_flit_vc),
        .s_valid       (s_valid),
        .s_is_tail     (s_is_tail),
        .s_vc_ready    (s_vc_ready),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_flit_data   (m_flit_data),
        .m_valid       (m_valid),
        .noc_ready     (noc_ready)
    );

    logic [43:0]  aw_q [$];
    logic [128:0] w_q [$];
    logic [127:0] rsp_q [$];
    int n_cmp      = 0;
    int n_err      = 0;
    int beats_seen = 0;
    int wl_cnt     = 0;
    int b_issued   = 0;
    logic [1:0] bresp_val = 2'd0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] src);
        logic [127:0] r;
        r = '0;
        r[31:0]  = addr;
        r[39:32] = len;
        r[43:40] = src;
        return r;
    endfunction

    function automatic logic [127:0] bodyd(input logic [31:0] base, input int i);
        return {base, 64'h0123_4567_89AB_CDEF, 32'(i)};
    endfunction

    // Response flit: SOURCE_ID 0xF in [3:0], requester in [7:4], bresp in [9:8]
    function automatic logic [127:0] rspf(input logic [3:0] src, input logic [1:0] br);
        logic [127:0] r;
        r = '0;
        r[3:0] = 4'hF;
        r[7:4] = src;
        r[9:8] = br;
        return r;
    endfunction

    // Monitor: handshakes seen at the negedge complete on the following posedge
    initial begin
        forever begin
            @(negedge noc_clk);
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("aw", {m_axi_awid, m_axi_awaddr, m_axi_awlen}, aw_q.pop_front());
            end
            if (m_axi_wvalid && m_axi_wready) begin
                beats_seen++;
                if (m_axi_wlast) wl_cnt++;
                if (w_q.size() == 0) chk("w_unexpected", 1, 0);
                else chk("w_beat", {m_axi_wlast, m_axi_wdata}, w_q.pop_front());
            end
            if (m_valid && noc_ready) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_flit", m_flit_data, rsp_q.pop_front());
            end
        end
    end

    // AXI B responder: one response per completed burst
    initial begin
        logic fire;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'd0;
        forever begin
            @(negedge noc_clk);
            fire = m_axi_bvalid && m_axi_bready;
            @(posedge noc_clk);
            #1;
            if (noc_rst) begin
                m_axi_bvalid = 1'b0;
                b_issued     = wl_cnt;
            end else if (m_axi_bvalid && fire) begin
                m_axi_bvalid = 1'b0;
            end else if (!m_axi_bvalid && b_issued != wl_cnt) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = bresp_val;
                b_issued++;
            end
        end
    end

    task automatic push(input int vc, input logic [127:0] d, input logic tail);
        int guard;
        guard       = 0;
        s_valid     = 1'b1;
        s_flit_vc   = vc[1:0];
        s_flit_data = d;
        s_is_tail   = tail;
        while (!s_vc_ready[vc] && guard < 200) begin
            @(posedge noc_clk);
            #1;
            guard++;
        end
        if (guard >= 200) chk("push_timeout", 1, 0);
        @(posedge noc_clk);
        #1;
        s_valid   = 1'b0;
        s_is_tail = 1'b0;
    endtask

    task automatic send_pkt(input int vc, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] src, input logic [31:0] base);
        push(vc, hdr(addr, len, src), 1'b0);
        for (int i = 0; i <= int'(len); i++) push(vc, bodyd(base, i), i == int'(len));
    endtask

    task automatic expect_pkt(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] src,
                              input logic [31:0] base, input logic [1:0] br);
        aw_q.push_back({src, addr, len});
        for (int i = 0; i <= int'(len); i++) w_q.push_back({i == int'(len), bodyd(base, i)});
`ifdef NSU_WR_RESP_EN
        rsp_q.push_back(rspf(src, br));
`else
        if (br == 2'd3) rsp_q.delete();
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((aw_q.size() != 0 || w_q.size() != 0 || rsp_q.size() != 0 ||
                dut.state != ST_IDLE || m_axi_bvalid) && n < 500) begin
            @(posedge noc_clk);
            #1;
            n++;
        end
        chk(tag, n < 500, 1);
    endtask

    task automatic do_reset();
        noc_rst = 1'b1;
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beats_seen < target && n < 300) begin
            @(posedge noc_clk);
            #1;
            n++;
        end
        chk("beat_wait", n < 300, 1);
    endtask

    initial begin
        int aw_seen;
        noc_rst     = 1'b1;
        s_valid     = 1'b0;
        s_is_tail   = 1'b0;
        s_flit_vc   = '0;
        s_flit_data = '0;
        noc_ready   = 1'b1;
        do_reset();

        @(negedge noc_clk);
        chk("rst_vc_ready", s_vc_ready, 4'hF);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_wlast", m_axi_wlast, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_flit", m_flit_data, 0);
        @(posedge noc_clk);
        #1;

        // Basic packet on VC0 and AW latency from tail acceptance
        expect_pkt(32'h1000, 8'd3, 4'd2, 32'h0000_00A0, 2'd0);
        send_pkt(0, 32'h1000, 8'd3, 4'd2, 32'h0000_00A0);
        @(negedge noc_clk); chk("aw_lat_c0", m_axi_awvalid, 0);
        @(negedge noc_clk); chk("aw_lat_c1", m_axi_awvalid, 0);
        @(negedge noc_clk); chk("aw_lat_c2", m_axi_awvalid, 1);
        @(posedge noc_clk); #1;
        wait_idle("t1_done");

        // Round-robin: VC1 and VC3 both pending while the engine is blocked on AW
        aw_hold = 1'b1;
        expect_pkt(32'h3000, 8'd0, 4'd3, 32'h0000_0030, 2'd0);
        send_pkt(3, 32'h3000, 8'd0, 4'd3, 32'h0000_0030);
        send_pkt(3, 32'h3100, 8'd1, 4'd5, 32'h0000_0031);
        send_pkt(1, 32'h1100, 8'd2, 4'd6, 32'h0000_0011);
        expect_pkt(32'h1100, 8'd2, 4'd6, 32'h0000_0011, 2'd0);
        expect_pkt(32'h3100, 8'd1, 4'd5, 32'h0000_0031, 2'd0);
        aw_hold = 1'b0;
        wait_idle("t2_done");
        chk("rr_ptr_end", dut.rr_ptr, 2'd0);

        // Fill VC2 without a tail, then offer one more flit
        for (int i = 0; i < 16; i++) push(2, bodyd(32'h22, i), 1'b0);
        chk("full_ready", s_vc_ready, 4'b1011);
        s_valid     = 1'b1;
        s_flit_vc   = 2'd2;
        s_is_tail   = 1'b1;
        s_flit_data = bodyd(32'h22, 16);
        @(posedge noc_clk); #1;
        s_valid   = 1'b0;
        s_is_tail = 1'b0;
        aw_seen   = 0;
        repeat (6) begin
            @(negedge noc_clk);
            if (m_axi_awvalid) aw_seen++;
        end
        chk("full_no_aw", aw_seen, 0);
        chk("full_ready_hold", s_vc_ready, 4'b1011);
        @(posedge noc_clk); #1;
        do_reset();
        chk("full_rst_ready", s_vc_ready, 4'hF);

        // wready stall for 5 cycles after beat 2
        bresp_val  = 2'd2;
        beats_seen = 0;
        expect_pkt(32'h2000, 8'd3, 4'd1, 32'h0000_0044, 2'd2);
        send_pkt(0, 32'h2000, 8'd3, 4'd1, 32'h0000_0044);
        wait_beats(2);
        w_hold = 1'b1;
        repeat (5) begin
            @(negedge noc_clk);
            chk("stall_wvalid", m_axi_wvalid, 1);
            chk("stall_wdata", m_axi_wdata, bodyd(32'h44, 2));
        end
        @(posedge noc_clk); #1;
        w_hold = 1'b0;
        wait_idle("t4_done");
        chk("stall_beats", beats_seen, 4);
        bresp_val = 2'd0;

        // Reset in the middle of a burst
        beats_seen = 0;
        expect_pkt(32'h4000, 8'd3, 4'd7, 32'h0000_0055, 2'd0);
        send_pkt(1, 32'h4000, 8'd3, 4'd7, 32'h0000_0055);
        wait_beats(2);
        noc_rst = 1'b1;
        w_q.delete();
        rsp_q.delete();
        @(posedge noc_clk); #1;
        noc_rst = 1'b0;
        @(negedge noc_clk);
        chk("mid_rst_awvalid", m_axi_awvalid, 0);
        chk("mid_rst_wvalid", m_axi_wvalid, 0);
        chk("mid_rst_wlast", m_axi_wlast, 0);
        chk("mid_rst_bready", m_axi_bready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_ready", s_vc_ready, 4'hF);
        chk("mid_rst_state", dut.state, ST_IDLE);
        aw_seen = 0;
        repeat (5) begin
            @(negedge noc_clk);
            if (m_axi_awvalid || m_axi_wvalid) aw_seen++;
        end
        chk("mid_rst_quiet", aw_seen, 0);
        @(posedge noc_clk); #1;
        beats_seen = 0;
        expect_pkt(32'h5000, 8'd1, 4'd9, 32'h0000_0066, 2'd0);
        send_pkt(1, 32'h5000, 8'd1, 4'd9, 32'h0000_0066);
        wait_idle("t5_done");
        chk("post_rst_beats", beats_seen, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nsu_vc_write_engine.md
NSU_VC_WRITE_ENGINE -- requirements
Module: nsu_vc_write_engine
Interface
REQ-001 SHALL have parameter DATA_WIDTH, 128, flit and AXI data width in bits.
REQ-002 SHALL have parameter VC_NUM, 4, number of virtual channels (power of two, 2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, 16, flits per VC buffer (power of two).
REQ-004 SHALL have parameter ID_WIDTH, 4, NoC node ID width, also used as AXI ID width.
REQ-005 SHALL have parameter AXI_ADDR_WIDTH, 32, AXI address width.
REQ-006 SHALL have parameter SOURCE_ID, {ID_WIDTH{1'b1}}, own node ID placed in response flits.
REQ-007 SHALL have port noc_clk  in  1  sole clock; all logic on the rising edge.
REQ-008 SHALL have port noc_rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have port s_flit_data  in  DATA_WIDTH  incoming flit payload.
REQ-010 SHALL have port s_flit_vc  in  $clog2(VC_NUM)  VC of the incoming flit.
REQ-011 SHALL have port s_valid  in  1  flit present.
REQ-012 SHALL have port s_is_tail  in  1  last flit of a packet.
REQ-013 SHALL have port s_vc_ready  out  VC_NUM  per-VC buffer not full.
REQ-014 SHALL have ports m_axi_awid (ID_WIDTH), m_axi_awaddr (AXI_ADDR_WIDTH), m_axi_awlen (8), m_axi_awvalid (1) as outputs and m_axi_awready (1) as input.
REQ-015 SHALL have ports m_axi_wdata (DATA_WIDTH), m_axi_wlast (1), m_axi_wvalid (1) as outputs and m_axi_wready (1) as input.
REQ-016 SHALL have ports m_axi_bresp (2) and m_axi_bvalid (1) as inputs and m_axi_bready (1) as output.
REQ-017 SHALL have ports m_flit_data (DATA_WIDTH) and m_valid (1) as outputs and noc_ready (1) as input; the response flit is single-flit, head and tail.
Function
REQ-018 SHALL accept a flit only when s_valid && s_vc_ready[s_flit_vc]; a flit offered to a full VC SHALL be ignored with no state change.
REQ-019 SHALL treat the first flit after reset or after a tail on a VC as the head flit, carrying addr at [AXI_ADDR_WIDTH-1:0], len (beats-1) at the next 8 bits, and src_id at the next ID_WIDTH bits; len+1 body flits follow, and the last carries s_is_tail.
REQ-020 SHALL keep a per-VC complete-packet counter: +1 on accepted tail, -1 when the engine pops that packet's head; a simultaneous +1/-1 SHALL leave it unchanged.
REQ-021 SHALL pick, in IDLE, the VC with counter>0 by round-robin starting at rr_ptr, and set rr_ptr to winner+1 mod VC_NUM.
REQ-022 SHALL run the FSM IDLE->HDR (pop head, latch fields, 1 cycle)->AW->W->B->RSP->IDLE; m_axi_awvalid SHALL rise 2 cycles after a packet is complete with the FSM in IDLE.
REQ-023 SHALL hold awvalid/awaddr/awlen/awid (src_id) stable until awready, then enter W.
REQ-024 SHALL drive m_axi_wvalid = selected VC FIFO not empty, pop on wvalid&&wready, assert wlast on beat count == len from the header (tail position not checked), and enter B after the last beat.
REQ-025 SHALL drive m_axi_bready=1 only in B, latch bresp on bvalid, and move to RSP.
REQ-026 SHALL, in RSP, assert m_valid with m_flit_data = {bresp, src_id as destination, SOURCE_ID} in the low bits, zero elsewhere, until noc_ready, then return to IDLE.
REQ-027 SHALL allow pushes to any VC, including the draining one, in every state; the AXI slave port is INCR, full-width, with all strobes implied.
Reset
REQ-028 SHALL, on noc_rst, empty all FIFOs, clear counters and rr_ptr, enter IDLE, and drive all valids, bready and wlast to 0 and s_vc_ready to all-ones on the next edge.
REQ-029 SHALL abandon any AXI burst in progress when reset is asserted mid-operation; no further beats or responses are issued.
Configuration
REQ-030 SHALL, with NSU_WR_RESP_EN defined, implement the RSP state; without it, B->IDLE directly, m_valid=0, m_flit_data=0.
Structure
REQ-031 SHALL place the header field offsets, FSM state encoding and response-flit layout constants in the shared package nsu_pkg.
REQ-032 SHALL implement each VC buffer as a sub-module nsu_vc_fifo (synchronous FIFO, FIFO_DEPTH) instantiated VC_NUM times.
Verification
REQ-033 SHALL cover: VC0 head addr=0x1000, len=3, src=2, plus 4 body flits -> AW 0x1000/len 3/id 2, 4 W beats, wlast on beat 4, response flit with bresp=0 and source 0xF.
REQ-034 SHALL cover: complete packets on VC1 and VC3 at the same time, rr_ptr=0 -> VC1 served first, then VC3, with rr_ptr=0 at the end.
REQ-035 SHALL cover: 16 flits pushed into VC2 with no drain -> s_vc_ready[2]=0, a 17th flit is ignored, and other VCs stay ready.
REQ-036 SHALL cover: wready low for 5 cycles mid-burst -> wdata and wvalid held, with no beat lost or duplicated.
REQ-037 SHALL cover: noc_rst asserted in W after 2 of 4 beats -> next cycle all valids=0, FSM in IDLE, all FIFOs empty.
